div_int_seq: RTL and testbench

// - Parametrised sequential non-restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.
// - Adds start/busy/done handshake, signed/unsigned mode, quotient-overflow flag and asynchronous reset.
// - Sits beside the ALU as the multi-cycle DIV/DIVU unit; the issue logic stalls on busy.

---
 rtl/div_int_seq_if.sv | 31 +++
 rtl/div_int_seq.sv | 204 ++++++++++++++++++++
 tb/tb_div_int_seq.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_int_seq_if.sv
// ----------------------------------------------------------------------------
// div_int_seq_if
// Handshake and data bundle for the sequential divider.
//   master (issue side) drives : start, signed_op, dnd[2W-1:0], der[W-1:0]
//   slave  (divider)    drives : busy, done, quo[W-1:0], rem[W-1:0], err, ovf
// Parameter W is the divisor/quotient/remainder width; the dividend is 2W bits.
// ----------------------------------------------------------------------------
interface div_int_seq_if #(
    parameter int W = 32
);
    logic           start;
    logic           signed_op;
    logic [2*W-1:0] dnd;
    logic [W-1:0]   der;
    logic           busy;
    logic           done;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic           err;
    logic           ovf;

    modport master (
        output start, signed_op, dnd, der,
        input  busy, done, quo, rem, err, ovf
    );

    modport slave (
        input  start, signed_op, dnd, der,
        output busy, done, quo, rem, err, ovf
    );
endinterface

// File: rtl/div_int_seq.sv
// ----------------------------------------------------------------------------
// div_int_seq
// Sequential non-restoring divider: 2W-bit dividend / W-bit divisor giving a
// W-bit quotient and W-bit remainder, signed (truncating toward zero) or
// unsigned. One quotient bit per clock.
//
// Ports
//   clk    in  clock, all state on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    div_int_seq_if.slave
//          start/signed_op/dnd/der sampled when busy=0
//          busy while an operation is in flight, done one-cycle result pulse
//          quo/rem/err/ovf held from one done to the next
//
// Timing: start sampled at edge 0, W RUN cycles, one FIX cycle, done high
// after edge W+1. A start seen in the done cycle launches the next operation.
//
// Optional build macro DIV_ZERO_BYPASS_EN: operations whose result is already
// known at capture (divide-by-zero, or quotient wider than W bits) leave RUN
// after its first cycle, so done rises after edge 2. Results are identical in
// both builds.
// ----------------------------------------------------------------------------
module div_int_seq #(
    parameter int W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    div_int_seq_if.slave bus
);
    localparam int              CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]   LAST = CW'(W - 1);
    localparam logic [W-1:0]    HALF = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    // Work registers: P is the signed partial remainder, A shifts dividend
    // bits out of its top and quotient bits into its bottom, B is |divisor|.
    logic [CW-1:0]   r_cnt;
    logic [W:0]      r_p;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_dnd_lo;
    logic            r_q_neg;
    logic            r_r_neg;
    logic            r_signed;
    logic            r_err_pend;
    logic            r_ovf_pend;

    // Result registers
    logic            r_done;
    logic            r_err;
    logic            r_ovf;
    logic [W-1:0]    r_quo;
    logic [W-1:0]    r_rem;

    // Capture-side operand conditioning
    logic            w_dnd_neg;
    logic            w_der_neg;
    logic [2*W-1:0]  w_dnd_mag;
    logic [W-1:0]    w_der_mag;
    logic            w_der_zero;
    logic            w_cap_ovf;
    logic            w_cap_bypass;

    // Iteration and fix-up datapath
    logic [W:0]      w_p_shift;
    logic [W:0]      w_p_step;
    logic            w_qbit;
    logic [W:0]      w_p_fix;
    logic [W-1:0]    w_r_mag;
    logic            w_sgn_ovf;

    assign w_dnd_neg  = bus.signed_op & bus.dnd[2*W-1];
    assign w_der_neg  = bus.signed_op & bus.der[W-1];
    assign w_dnd_mag  = w_dnd_neg ? -bus.dnd : bus.dnd;
    assign w_der_mag  = w_der_neg ? -bus.der : bus.der;
    assign w_der_zero = (bus.der == '0);
    // If the upper half already reaches the divisor the quotient needs more
    // than W bits. In signed mode this catches magnitudes of 2^W and above;
    // the finer signed range check happens in FIX.
    assign w_cap_ovf  = !w_der_zero && (w_dnd_mag[2*W-1:W] >= w_der_mag);
`ifdef DIV_ZERO_BYPASS_EN
    assign w_cap_bypass = w_der_zero | w_cap_ovf;
`else
    assign w_cap_bypass = 1'b0;
`endif

    // The add/subtract decision uses the sign of P before the shift. The
    // shifted value may wrap in W+1 bits, but the post-step value always lies
    // in [-B, B) so the modular result is exact.
    assign w_p_shift = {r_p[W-1:0], r_a[W-1]};
    assign w_p_step  = r_p[W] ? (w_p_shift + {1'b0, r_b})
                              : (w_p_shift - {1'b0, r_b});
    assign w_qbit    = ~w_p_step[W];

    assign w_p_fix   = r_p[W] ? (r_p + {1'b0, r_b}) : r_p;
    assign w_r_mag   = w_p_fix[W-1:0];
    // Signed range: a negative result may reach 2^(W-1), a positive one only
    // 2^(W-1)-1 (i.e. its top magnitude bit must be clear).
    assign w_sgn_ovf = r_signed && (r_q_neg ? (r_a > HALF) : r_a[W-1]);

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_next = S_RUN;
            S_RUN:  if (r_cnt == LAST) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_p        <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_dnd_lo   <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_signed   <= 1'b0;
            r_err_pend <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
            r_quo      <= '0;
            r_rem      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_p        <= {1'b0, w_dnd_mag[2*W-1:W]};
                        r_a        <= w_dnd_mag[W-1:0];
                        r_b        <= w_der_mag;
                        r_dnd_lo   <= bus.dnd[W-1:0];
                        r_q_neg    <= w_dnd_neg ^ w_der_neg;
                        r_r_neg    <= w_dnd_neg;
                        r_signed   <= bus.signed_op;
                        r_err_pend <= w_der_zero;
                        r_ovf_pend <= w_cap_ovf;
                        // Results known at capture only need one RUN cycle
                        r_cnt      <= w_cap_bypass ? LAST : '0;
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_step;
                    r_a   <= {r_a[W-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_err_pend) begin
                        r_err <= 1'b1;
                        r_ovf <= 1'b0;
                        r_quo <= '1;
                        r_rem <= r_dnd_lo;
                    end else if (r_ovf_pend || w_sgn_ovf) begin
                        r_err <= 1'b0;
                        r_ovf <= 1'b1;
                        r_quo <= '1;
                        r_rem <= '0;
                    end else begin
                        r_err <= 1'b0;
                        r_ovf <= 1'b0;
                        r_quo <= r_q_neg ? -r_a : r_a;
                        r_rem <= r_r_neg ? -w_r_mag : w_r_mag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.quo  = r_quo;
    assign bus.rem  = r_rem;
    assign bus.err  = r_err;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_div_int_seq.sv
// ----------------------------------------------------------------------------
// tb_div_int_seq
// Directed-vector bench for div_int_seq (W=32). Inputs change and outputs are
// sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_div_int_seq;
    localparam int W   = 32;
    localparam int LAT = W + 1;
`ifdef DIV_ZERO_BYPASS_EN
    localparam int LAT_EARLY = 2;
`else
    localparam int LAT_EARLY = W + 1;
`endif

    typedef struct {
        logic            sop;
        logic [2*W-1:0]  a;
        logic [W-1:0]    b;
        logic [W-1:0]    q;
        logic [W-1:0]    r;
        logic            e;
        logic            o;
        int              lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    div_int_seq_if #(.W(W)) bus ();

    div_int_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic sop, input logic [2*W-1:0] a, input logic [W-1:0] b);
        bus.start     = 1'b1;
        bus.signed_op = sop;
        bus.dnd       = a;
        bus.der       = b;
        step();
        bus.start     = 1'b0;
    endtask

    // Counts edges after the start edge until done; gives up after 200.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!bus.done && cyc < 200);
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({bus.busy, bus.done, bus.err, bus.ovf, bus.quo, bus.rem} !== '0) begin
            n_miss++;
            $display("FAIL reset_hold got busy=%b done=%b err=%b ovf=%b quo=%h rem=%h want all 0",
                     bus.busy, bus.done, bus.err, bus.ovf, bus.quo, bus.rem);
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        n_vec++;
        if ({bus.busy, bus.done, bus.err, bus.ovf, bus.quo, bus.rem} !== '0) begin
            n_miss++;
            $display("FAIL reset_release got busy=%b done=%b quo=%h rem=%h want all 0",
                     bus.busy, bus.done, bus.quo, bus.rem);
        end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_unsigned();
        vec_t v[4];
        int   cyc;
        v[0] = '{1'b0, 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, LAT};
        v[1] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0, LAT};
        v[2] = '{1'b0, 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, LAT};
        v[3] = '{1'b0, 64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, LAT};
        for (int i = 0; i < 4; i++) begin
            launch(v[i].sop, v[i].a, v[i].b);
            wait_done(cyc);
            $display("unsigned[%0d]: %h / %h -> quo=%h rem=%h err=%b ovf=%b after %0d cycles",
                     i, v[i].a, v[i].b, bus.quo, bus.rem, bus.err, bus.ovf, cyc);
            n_vec++;
            if (cyc !== v[i].lat) begin
                n_miss++;
                $display("FAIL unsigned[%0d] latency got %0d want %0d", i, cyc, v[i].lat);
            end
            n_vec++;
            if ({bus.quo, bus.rem, bus.err, bus.ovf} !== {v[i].q, v[i].r, v[i].e, v[i].o}) begin
                n_miss++;
                $display("FAIL unsigned[%0d] result got quo=%h rem=%h err=%b ovf=%b want quo=%h rem=%h err=%b ovf=%b",
                         i, bus.quo, bus.rem, bus.err, bus.ovf, v[i].q, v[i].r, v[i].e, v[i].o);
            end
            if (i == 0) begin
                n_vec++;
                if (bus.busy !== 1'b0) begin
                    n_miss++;
                    $display("FAIL busy_in_done got %b want 0", bus.busy);
                end
                step();
                n_vec++;
                if ({bus.done, bus.quo} !== {1'b0, 32'd14}) begin
                    n_miss++;
                    $display("FAIL done_pulse got done=%b quo=%h want done=0 quo=0000000e", bus.done, bus.quo);
                end
            end
        end
    endtask

    task automatic test_signed();
        vec_t v[4];
        int   cyc;
        v[0] = '{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, LAT};
        v[1] = '{1'b1, 64'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, LAT};
        v[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, LAT};
        v[3] = '{1'b1, 64'hFFFF_FFFF_8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, LAT};
        for (int i = 0; i < 4; i++) begin
            launch(v[i].sop, v[i].a, v[i].b);
            wait_done(cyc);
            $display("signed[%0d]: %h / %h -> quo=%h rem=%h err=%b ovf=%b after %0d cycles",
                     i, v[i].a, v[i].b, bus.quo, bus.rem, bus.err, bus.ovf, cyc);
            n_vec++;
            if (cyc !== v[i].lat) begin
                n_miss++;
                $display("FAIL signed[%0d] latency got %0d want %0d", i, cyc, v[i].lat);
            end
            n_vec++;
            if ({bus.quo, bus.rem, bus.err, bus.ovf} !== {v[i].q, v[i].r, v[i].e, v[i].o}) begin
                n_miss++;
                $display("FAIL signed[%0d] result got quo=%h rem=%h err=%b ovf=%b want quo=%h rem=%h err=%b ovf=%b",
                         i, bus.quo, bus.rem, bus.err, bus.ovf, v[i].q, v[i].r, v[i].e, v[i].o);
            end
        end
    endtask

    task automatic test_div_zero();
        vec_t v[2];
        int   cyc;
        v[0] = '{1'b0, 64'h1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0, LAT_EARLY};
        v[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 1'b0, LAT_EARLY};
        for (int i = 0; i < 2; i++) begin
            launch(v[i].sop, v[i].a, v[i].b);
            wait_done(cyc);
            $display("divzero[%0d]: %h / %h -> quo=%h rem=%h err=%b ovf=%b after %0d cycles",
                     i, v[i].a, v[i].b, bus.quo, bus.rem, bus.err, bus.ovf, cyc);
            n_vec++;
            if (cyc !== v[i].lat) begin
                n_miss++;
                $display("FAIL divzero[%0d] latency got %0d want %0d", i, cyc, v[i].lat);
            end
            n_vec++;
            if ({bus.quo, bus.rem, bus.err, bus.ovf} !== {v[i].q, v[i].r, v[i].e, v[i].o}) begin
                n_miss++;
                $display("FAIL divzero[%0d] result got quo=%h rem=%h err=%b ovf=%b want quo=%h rem=%h err=%b ovf=%b",
                         i, bus.quo, bus.rem, bus.err, bus.ovf, v[i].q, v[i].r, v[i].e, v[i].o);
            end
        end
    endtask

    task automatic test_overflow();
        vec_t v[5];
        int   cyc;
        v[0] = '{1'b0, 64'h1_0000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, LAT_EARLY};
        v[1] = '{1'b0, 64'h0000_0007_0000_0000, 32'd7, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, LAT_EARLY};
        v[2] = '{1'b1, 64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, LAT};
        v[3] = '{1'b1, 64'h0000_0000_8000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, LAT};
        v[4] = '{1'b1, 64'h0000_0000_7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0, LAT};
        for (int i = 0; i < 5; i++) begin
            launch(v[i].sop, v[i].a, v[i].b);
            wait_done(cyc);
            $display("overflow[%0d]: %h / %h -> quo=%h rem=%h err=%b ovf=%b after %0d cycles",
                     i, v[i].a, v[i].b, bus.quo, bus.rem, bus.err, bus.ovf, cyc);
            n_vec++;
            if (cyc !== v[i].lat) begin
                n_miss++;
                $display("FAIL overflow[%0d] latency got %0d want %0d", i, cyc, v[i].lat);
            end
            n_vec++;
            if ({bus.quo, bus.rem, bus.err, bus.ovf} !== {v[i].q, v[i].r, v[i].e, v[i].o}) begin
                n_miss++;
                $display("FAIL overflow[%0d] result got quo=%h rem=%h err=%b ovf=%b want quo=%h rem=%h err=%b ovf=%b",
                         i, bus.quo, bus.rem, bus.err, bus.ovf, v[i].q, v[i].r, v[i].e, v[i].o);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        launch(1'b0, 64'd100, 32'd7);
        cyc = 0;
        do begin
            // Stray requests with different operands land on edges 5 and 10
            bus.start = (cyc == 4 || cyc == 9);
            if (bus.start) begin
                bus.signed_op = 1'b1;
                bus.dnd       = 64'd999;
                bus.der       = 32'd3;
            end
            step();
            cyc++;
            if (cyc == 5) begin
                n_vec++;
                if (bus.busy !== 1'b1) begin
                    n_miss++;
                    $display("FAIL busy_mid_op got %b want 1", bus.busy);
                end
            end
        end while (!bus.done && cyc < 200);
        bus.start = 1'b0;
        $display("busy_ignore: 100 / 7 with strays -> quo=%h rem=%h after %0d cycles", bus.quo, bus.rem, cyc);
        n_vec++;
        if (cyc !== LAT) begin
            n_miss++;
            $display("FAIL busy_ignore latency got %0d want %0d", cyc, LAT);
        end
        n_vec++;
        if ({bus.quo, bus.rem, bus.err, bus.ovf} !== {32'd14, 32'd2, 1'b0, 1'b0}) begin
            n_miss++;
            $display("FAIL busy_ignore result got quo=%h rem=%h err=%b ovf=%b want quo=0000000e rem=00000002 err=0 ovf=0",
                     bus.quo, bus.rem, bus.err, bus.ovf);
        end
        step();
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_miss++;
            $display("FAIL busy_ignore_relaunch got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        launch(1'b0, 64'd1000, 32'd9);
        wait_done(cyc);
        $display("b2b first: 1000 / 9 -> quo=%h rem=%h after %0d cycles", bus.quo, bus.rem, cyc);
        n_vec++;
        if ({bus.quo, bus.rem} !== {32'd111, 32'd1}) begin
            n_miss++;
            $display("FAIL b2b_first got quo=%h rem=%h want quo=0000006f rem=00000001", bus.quo, bus.rem);
        end
        // Launch the second operation from the done cycle
        launch(1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 32'd7);
        n_vec++;
        if ({bus.busy, bus.quo, bus.rem} !== {1'b1, 32'd111, 32'd1}) begin
            n_miss++;
            $display("FAIL b2b_hold got busy=%b quo=%h rem=%h want busy=1 quo=0000006f rem=00000001",
                     bus.busy, bus.quo, bus.rem);
        end
        wait_done(cyc);
        $display("b2b second: -100 / 7 -> quo=%h rem=%h after %0d cycles", bus.quo, bus.rem, cyc);
        n_vec++;
        if (cyc !== LAT) begin
            n_miss++;
            $display("FAIL b2b_latency got %0d want %0d", cyc, LAT);
        end
        n_vec++;
        if ({bus.quo, bus.rem} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE}) begin
            n_miss++;
            $display("FAIL b2b_second got quo=%h rem=%h want quo=fffffff2 rem=fffffffe", bus.quo, bus.rem);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        launch(1'b0, 64'd5000, 32'd3);
        for (int i = 0; i < 15; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        $display("async_reset: asserted mid-operation, busy=%b quo=%h rem=%h", bus.busy, bus.quo, bus.rem);
        n_vec++;
        if ({bus.busy, bus.done, bus.err, bus.ovf, bus.quo, bus.rem} !== '0) begin
            n_miss++;
            $display("FAIL async_reset got busy=%b done=%b err=%b ovf=%b quo=%h rem=%h want all 0",
                     bus.busy, bus.done, bus.err, bus.ovf, bus.quo, bus.rem);
        end
        step();
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_miss++;
            $display("FAIL async_reset_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        launch(1'b1, 64'd100, 32'hFFFF_FFF9);
        wait_done(cyc);
        $display("after_reset: 100 / -7 -> quo=%h rem=%h after %0d cycles", bus.quo, bus.rem, cyc);
        n_vec++;
        if (cyc !== LAT) begin
            n_miss++;
            $display("FAIL after_reset latency got %0d want %0d", cyc, LAT);
        end
        n_vec++;
        if ({bus.quo, bus.rem, bus.err, bus.ovf} !== {32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0}) begin
            n_miss++;
            $display("FAIL after_reset result got quo=%h rem=%h err=%b ovf=%b want quo=fffffff2 rem=00000002 err=0 ovf=0",
                     bus.quo, bus.rem, bus.err, bus.ovf);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dnd       = '0;
        bus.der       = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_start_while_busy();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
